tournament_predictor: RTL and testbench
=======================================

# tournament_predictor

Fetch-stage branch direction predictor that feeds the IF/ID pipeline register. Each cycle it looks up the fetch PC in a local (PC-indexed) table, a global gshare table (PC XOR history) and a chooser table, and it produces a taken/not-taken prediction plus the raw counters and history snapshot that travel down the pipeline with the instruction. When a branch resolves in EX, those carried values come back on the update port, and the block trains all three tables and the branch history register (BHR).

## Interface
Parameters:
- bhr_width, 10: global history length; also the gshare index width.
- idx_width, 10: local-table and chooser-table index width (2^idx_width entries each).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- pc_in  in  32  fetch PC for the lookup.
- taken_out  out  1  predicted direction.
- pred_out  out  2  chooser counter read at lookup.
- local_pred_out  out  2  local counter read at lookup.
- global_pred_out  out  2  gshare counter read at lookup.
- bhr_out  out  bhr_width  BHR value used for this lookup.
- upd_valid  in  1  a branch resolved in EX this cycle; train on this edge.
- upd_pc  in  32  PC of the resolved branch.
- upd_taken  in  1  actual direction.
- upd_pred, upd_local_pred, upd_global_pred  in  2 each  counters carried from lookup.
- upd_bhr  in  bhr_width  BHR snapshot carried from lookup.

## Operation
- Counters are 2-bit saturating. Encoding: 0 = strongly not-taken (SNT), 1 = weakly not-taken (WNT), 2 = weakly taken (WT), 3 = strongly taken (ST).
  - Increment saturates at 3; decrement saturates at 0.
- Chooser encoding: 0 and 1 select local; 2 and 3 select global.
- Lookup indices:
  - Local and chooser: li = pc_in[idx_width+1:2].
  - Global: gi = pc_in[bhr_width+1:2] ^ bhr.
- Lookup outputs:
  - local_pred_out = LT[li], global_pred_out = GT[gi], pred_out = CT[li], bhr_out = bhr.
  - taken_out = pred_out[1] ? global_pred_out[1] : local_pred_out[1].
- Update (upd_valid=1). Indices are recomputed from upd_pc and upd_bhr, never from the current bhr:
  - LT[upd_li] steps from upd_local_pred toward upd_taken (increment if taken, else decrement).
  - GT[upd_bhr ^ upd_pc[bhr_width+1:2]] steps from upd_global_pred the same way.
  - Chooser: lc = (upd_local_pred[1]==upd_taken), gc = (upd_global_pred[1]==upd_taken).
    - lc and not gc: CT[upd_li] = sat_dec(upd_pred).
    - gc and not lc: CT[upd_li] = sat_inc(upd_pred).
    - Otherwise CT is not written.
  - BHR is non-speculative: bhr <= {bhr[bhr_width-2:0], upd_taken}.
- New counter values are computed from the carried upd_* values, not re-read from the tables. Interleaved branches to the same entry therefore last-writer-wins by design.
- Because the BHR is non-speculative, a mispredict needs no history repair. Flushed branches must never raise upd_valid.

## Timing
- Lookup is combinational. pc_in to all outputs resolves in the same cycle, and if_id_reg captures them at the next edge.
- Update takes effect at the rising edge where upd_valid=1 and is visible to lookups in the following cycle.
- Lookup and update to the same entry in the same cycle: the lookup returns the pre-update value.
- The update port is single-ported: at most one update per cycle. EX asserts upd_valid for exactly one cycle per resolved branch, even under stall.
- Reset: on any edge with rst=1, every LT, GT and CT entry goes to 1 (WNT / weakly local) and bhr goes to 0.
  - An update presented in a reset cycle is dropped.
  - After reset: taken_out=0, pred_out=1, local_pred_out=1, global_pred_out=1, bhr_out=0 for any pc_in.
- No internal FSM and no multi-cycle operations. State is the three tables plus the BHR.

## Structure
- Shared package (rv32i_types) holds:
  - typedef bp_ctr_t (logic [1:0]).
  - Constants BP_SNT, BP_WNT, BP_WT, BP_ST.
  - Functions sat_inc and sat_dec.
- One sub-module, bp_counter_table #(idx_w):
  - Combinational read port, one synchronous write port.
  - Synchronous reset of every entry to BP_WNT.
- It is instantiated three times (LT, CT, GT); GT uses idx_w = bhr_width.

## Test plan
- Reset, then any pc_in (e.g. 0x60) -> taken_out=0, all counters = 1, bhr_out=0.
- Same PC 0x100 updated taken three times, carrying the previously read counters each time -> local_pred_out = 3 and taken_out=1; bhr_out = 0b111.
- upd_local_pred=2, upd_global_pred=1, upd_pred=1, upd_taken=0 (global right, local wrong) -> CT entry becomes 2 and the prediction now follows global.
- Lookup and update to the same index in one cycle -> same-cycle output shows the old counter; the next cycle shows the new one.
- Saturation: updates with upd_local_pred=3, taken=1 -> entry stays 3. Updates with upd_local_pred=0, taken=0 -> entry stays 0.
- rst asserted in the same cycle as upd_valid -> update discarded and all state at reset values next cycle.

Source files
------------

// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared branch-predictor counter types and helpers
package rv32i_types;

    typedef logic [1:0] bp_ctr_t;

    localparam bp_ctr_t BP_SNT = 2'd0;
    localparam bp_ctr_t BP_WNT = 2'd1;
    localparam bp_ctr_t BP_WT  = 2'd2;
    localparam bp_ctr_t BP_ST  = 2'd3;

    function automatic bp_ctr_t sat_inc(input bp_ctr_t c);
        return (c == BP_ST) ? BP_ST : bp_ctr_t'(c + 2'd1);
    endfunction

    function automatic bp_ctr_t sat_dec(input bp_ctr_t c);
        return (c == BP_SNT) ? BP_SNT : bp_ctr_t'(c - 2'd1);
    endfunction

endpackage

// File: rtl/bp_counter_table.sv
// rtl/bp_counter_table.sv - 2-bit counter array, async read, sync write, reset to WNT
module bp_counter_table
    import rv32i_types::*;
#(
    parameter int idx_w = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [idx_w-1:0] rd_idx,
    output bp_ctr_t          rd_data,
    input  logic             wr_en,
    input  logic [idx_w-1:0] wr_idx,
    input  bp_ctr_t          wr_data
);

    localparam int DEPTH = 1 << idx_w;

    bp_ctr_t mem_q [DEPTH];
    bp_ctr_t mem_d [DEPTH];

    assign rd_data = mem_q[rd_idx];

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_idx] = wr_data;
        end
    end

    // Reset has priority, so an update in a reset cycle is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= BP_WNT;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/tournament_predictor.sv
// rtl/tournament_predictor.sv - local/gshare tournament branch direction predictor
module tournament_predictor
    import rv32i_types::*;
#(
    parameter int bhr_width = 10,
    parameter int idx_width = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          pc_in,
    output logic                 taken_out,
    output bp_ctr_t              pred_out,
    output bp_ctr_t              local_pred_out,
    output bp_ctr_t              global_pred_out,
    output logic [bhr_width-1:0] bhr_out,
    input  logic                 upd_valid,
    input  logic [31:0]          upd_pc,
    input  logic                 upd_taken,
    input  bp_ctr_t              upd_pred,
    input  bp_ctr_t              upd_local_pred,
    input  bp_ctr_t              upd_global_pred,
    input  logic [bhr_width-1:0] upd_bhr
);

    logic [bhr_width-1:0] bhr_q, bhr_d;
    logic [idx_width-1:0] li, upd_li;
    logic [bhr_width-1:0] gi, upd_gi;
    bp_ctr_t              lt_wdata, gt_wdata, ct_wdata;
    logic                 local_correct, global_correct, ct_we;
    logic                 unused_pc;

    assign unused_pc = ^{pc_in, upd_pc};

    assign li     = pc_in[idx_width+1:2];
    assign gi     = pc_in[bhr_width+1:2] ^ bhr_q;
    assign upd_li = upd_pc[idx_width+1:2];
    assign upd_gi = upd_pc[bhr_width+1:2] ^ upd_bhr;

    // New values come from the carried counters, not a table re-read.
    always_comb begin
        lt_wdata       = upd_taken ? sat_inc(upd_local_pred) : sat_dec(upd_local_pred);
        gt_wdata       = upd_taken ? sat_inc(upd_global_pred) : sat_dec(upd_global_pred);
        local_correct  = (upd_local_pred[1] == upd_taken);
        global_correct = (upd_global_pred[1] == upd_taken);
        ct_we          = upd_valid && (local_correct != global_correct);
        ct_wdata       = local_correct ? sat_dec(upd_pred) : sat_inc(upd_pred);
        bhr_d          = bhr_q;
        if (upd_valid) begin
            bhr_d = {bhr_q[bhr_width-2:0], upd_taken};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bhr_q <= '0;
        end else begin
            bhr_q <= bhr_d;
        end
    end

    bp_counter_table #(.idx_w(idx_width)) u_lt (
        .clk     (clk),
        .rst     (rst),
        .rd_idx  (li),
        .rd_data (local_pred_out),
        .wr_en   (upd_valid),
        .wr_idx  (upd_li),
        .wr_data (lt_wdata)
    );

    bp_counter_table #(.idx_w(idx_width)) u_ct (
        .clk     (clk),
        .rst     (rst),
        .rd_idx  (li),
        .rd_data (pred_out),
        .wr_en   (ct_we),
        .wr_idx  (upd_li),
        .wr_data (ct_wdata)
    );

    bp_counter_table #(.idx_w(bhr_width)) u_gt (
        .clk     (clk),
        .rst     (rst),
        .rd_idx  (gi),
        .rd_data (global_pred_out),
        .wr_en   (upd_valid),
        .wr_idx  (upd_gi),
        .wr_data (gt_wdata)
    );

    assign taken_out = pred_out[1] ? global_pred_out[1] : local_pred_out[1];
    assign bhr_out   = bhr_q;

endmodule

// File: tb/tb_tournament_predictor.sv
// tb/tb_tournament_predictor.sv - directed vector table plus randomized model check
module tb_tournament_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic        taken_out;
    logic [1:0]  pred_out, local_pred_out, global_pred_out;
    logic [9:0]  bhr_out;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [1:0]  upd_pred, upd_local_pred, upd_global_pred;
    logic [9:0]  upd_bhr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tournament_predictor #(.bhr_width(10), .idx_width(10)) dut (
        .clk             (clk),
        .rst             (rst),
        .pc_in           (pc_in),
        .taken_out       (taken_out),
        .pred_out        (pred_out),
        .local_pred_out  (local_pred_out),
        .global_pred_out (global_pred_out),
        .bhr_out         (bhr_out),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .upd_pred        (upd_pred),
        .upd_local_pred  (upd_local_pred),
        .upd_global_pred (upd_global_pred),
        .upd_bhr         (upd_bhr)
    );

    typedef struct {
        bit          rst;
        bit          chk;
        logic [31:0] pc;
        bit          uv;
        logic [31:0] upc;
        bit          ut;
        logic [1:0]  up, ul, ug;
        logic [9:0]  ub;
        bit          et;
        logic [1:0]  ep, el, eg;
        logic [9:0]  eb;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        int          ct, lt, gt, bhr;
    } look_t;

    vec_t  vecs [15];
    look_t pend [$];

    int m_lt [1024];
    int m_gt [1024];
    int m_ct [1024];
    int m_bhr;

    function automatic vec_t mk(bit r, bit c, logic [31:0] pc, bit uv, logic [31:0] upc,
                                bit ut, int up, int ul, int ug, int ub,
                                bit et, int ep, int el, int eg, int eb);
        vec_t v;
        v.rst = r;  v.chk = c;  v.pc = pc;  v.uv = uv;  v.upc = upc;  v.ut = ut;
        v.up = 2'(up);  v.ul = 2'(ul);  v.ug = 2'(ug);  v.ub = 10'(ub);
        v.et = et;  v.ep = 2'(ep);  v.el = 2'(el);  v.eg = 2'(eg);  v.eb = 10'(eb);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int step_ctr(int v, bit t);
        if (t) return (v == 3) ? 3 : v + 1;
        return (v == 0) ? 0 : v - 1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 1024; i++) begin
            m_lt[i] = 1;
            m_gt[i] = 1;
            m_ct[i] = 1;
        end
        m_bhr = 0;
    endtask

    initial begin
        int li, gi, eloc, eglb, ech, etk, uli, ugi;
        bit lc, gc;
        look_t lk, u;

        vecs[0]  = mk(1, 0, 32'h60,  0, 0,       0, 0, 0, 0, 0,     0, 0, 0, 0, 0);
        vecs[1]  = mk(0, 1, 32'h60,  0, 0,       0, 0, 0, 0, 0,     0, 1, 1, 1, 0);
        vecs[2]  = mk(0, 1, 32'h100, 1, 32'h100, 1, 1, 1, 1, 0,     0, 1, 1, 1, 0);
        vecs[3]  = mk(0, 1, 32'h100, 1, 32'h100, 1, 1, 2, 1, 1,     1, 1, 2, 1, 1);
        vecs[4]  = mk(0, 1, 32'h100, 1, 32'h100, 1, 0, 3, 1, 3,     1, 0, 3, 1, 3);
        vecs[5]  = mk(0, 1, 32'h100, 0, 0,       0, 0, 0, 0, 0,     1, 0, 3, 1, 7);
        vecs[6]  = mk(0, 1, 32'h200, 1, 32'h200, 1, 1, 3, 2, 'h1E,  0, 1, 1, 1, 7);
        vecs[7]  = mk(0, 1, 32'h200, 1, 32'h200, 0, 1, 2, 1, 'hF,   1, 1, 3, 1, 'hF);
        vecs[8]  = mk(0, 1, 32'h200, 0, 0,       0, 0, 0, 0, 0,     1, 2, 1, 3, 'h1E);
        vecs[9]  = mk(0, 1, 32'h300, 1, 32'h300, 1, 1, 1, 1, 'h1E,  0, 1, 1, 1, 'h1E);
        vecs[10] = mk(0, 1, 32'h300, 0, 0,       0, 0, 0, 0, 0,     1, 1, 2, 1, 'h3D);
        vecs[11] = mk(0, 1, 32'h400, 1, 32'h400, 0, 1, 0, 0, 'h3D,  0, 1, 1, 1, 'h3D);
        vecs[12] = mk(0, 1, 32'h400, 1, 32'h400, 0, 1, 0, 0, 'h7A,  0, 1, 0, 1, 'h7A);
        vecs[13] = mk(1, 0, 32'h100, 1, 32'h100, 1, 1, 2, 2, 'hF4,  0, 0, 0, 0, 0);
        vecs[14] = mk(0, 1, 32'h200, 0, 0,       0, 0, 0, 0, 0,     0, 1, 1, 1, 0);

        rst = 1'b1;  pc_in = '0;  upd_valid = 1'b0;  upd_pc = '0;  upd_taken = 1'b0;
        upd_pred = '0;  upd_local_pred = '0;  upd_global_pred = '0;  upd_bhr = '0;

        for (int i = 0; i < 15; i++) begin
            rst = vecs[i].rst;  pc_in = vecs[i].pc;  upd_valid = vecs[i].uv;
            upd_pc = vecs[i].upc;  upd_taken = vecs[i].ut;  upd_pred = vecs[i].up;
            upd_local_pred = vecs[i].ul;  upd_global_pred = vecs[i].ug;  upd_bhr = vecs[i].ub;
            @(negedge clk);
            if (vecs[i].chk) begin
                chk($sformatf("v%0d.taken", i),  32'(taken_out),       32'(vecs[i].et));
                chk($sformatf("v%0d.pred", i),   32'(pred_out),        32'(vecs[i].ep));
                chk($sformatf("v%0d.local", i),  32'(local_pred_out),  32'(vecs[i].el));
                chk($sformatf("v%0d.global", i), 32'(global_pred_out), 32'(vecs[i].eg));
                chk($sformatf("v%0d.bhr", i),    32'(bhr_out),         32'(vecs[i].eb));
            end
            @(posedge clk);
            #1;
        end

        // Randomized phase: begin from a reset so the model starts aligned.
        rst = 1'b1;  upd_valid = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        pend.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst = ($urandom_range(0, 199) == 0);
            pc_in = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 47)) << 2) | 32'($urandom_range(0, 3));
            upd_valid = 1'b0;
            if (pend.size() > 0 && ($urandom_range(0, 2) != 0)) begin
                u = pend.pop_front();
                upd_valid = 1'b1;
                upd_pc = u.pc;
                upd_taken = 1'($urandom_range(0, 1));
                upd_pred = 2'(u.ct);
                upd_local_pred = 2'(u.lt);
                upd_global_pred = 2'(u.gt);
                upd_bhr = 10'(u.bhr);
            end

            li   = int'((pc_in >> 2) % 1024);
            gi   = li ^ m_bhr;
            eloc = m_lt[li];
            eglb = m_gt[gi];
            ech  = m_ct[li];
            etk  = (ech >= 2) ? int'(eglb >= 2) : int'(eloc >= 2);

            @(negedge clk);
            chk("rnd.taken",  32'(taken_out),       32'(etk));
            chk("rnd.pred",   32'(pred_out),        32'(ech));
            chk("rnd.local",  32'(local_pred_out),  32'(eloc));
            chk("rnd.global", 32'(global_pred_out), 32'(eglb));
            chk("rnd.bhr",    32'(bhr_out),         32'(m_bhr));

            lk.pc = pc_in;  lk.ct = ech;  lk.lt = eloc;  lk.gt = eglb;  lk.bhr = m_bhr;
            if (pend.size() < 6) pend.push_back(lk);

            if (rst) begin
                model_reset();
                pend.delete();
            end else if (upd_valid) begin
                uli = int'((upd_pc >> 2) % 1024);
                ugi = uli ^ int'(upd_bhr);
                m_lt[uli] = step_ctr(int'(upd_local_pred), upd_taken);
                m_gt[ugi] = step_ctr(int'(upd_global_pred), upd_taken);
                lc = (upd_local_pred >= 2) == upd_taken;
                gc = (upd_global_pred >= 2) == upd_taken;
                if (lc && !gc) m_ct[uli] = step_ctr(int'(upd_pred), 1'b0);
                if (gc && !lc) m_ct[uli] = step_ctr(int'(upd_pred), 1'b1);
                m_bhr = ((m_bhr * 2) + int'(upd_taken)) % 1024;
            end
            @(posedge clk);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
